// File: rtl/mult_sequencer.sv
// mult_sequencer: buffers signed operand pairs in a small FIFO and issues them one at a
// time to an external fixed-latency multiplier, holding each product until it is consumed.
module mult_sequencer #(
    parameter int nb    = 32,
    parameter int DEPTH = 4,
    parameter int LAT   = nb + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [nb-1:0]      in_a,
    input  logic signed [nb-1:0]      in_b,
    output logic                      mul_start,
    output logic signed [nb-1:0]      mul_a,
    output logic signed [nb-1:0]      mul_b,
    input  logic signed [2*nb-1:0]    mul_product,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*nb-1:0]    out_product,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t               state, next_state;
    logic signed [nb-1:0] mem_a [DEPTH];
    logic signed [nb-1:0] mem_b [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 push, pop, load_ops, capture, hs_out;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Ready depends only on the registered level, so a same-cycle pop never frees a slot early.
    assign in_ready = (fifo_level != LW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                fifo_level <= fifo_level + LW'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (fifo_level != '0) next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT:  if (cnt == CW'(LAT - 1)) next_state = HOLD;
            HOLD:  if (out_ready) next_state = (fifo_level != '0) ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands and the start pulse are registered on entry to ISSUE, so they are valid for
    // exactly the ISSUE cycle; the head is popped as ISSUE is left.
    always_comb begin
        pop      = (state == ISSUE);
        load_ops = (next_state == ISSUE);
        capture  = (state == WAIT) && (cnt == CW'(LAT - 1));
        hs_out   = (state == HOLD) && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            mul_start <= load_ops;
            if (load_ops) begin
                mul_a <= mem_a[rd_ptr];
                mul_b <= mem_b[rd_ptr];
            end
            // The edge leaving ISSUE samples mul_start and counts as zero.
            if (state == WAIT) cnt <= cnt + CW'(1);
            else               cnt <= '0;
            if (capture) begin
                out_product <= mul_product;
                out_valid   <= 1'b1;
            end else if (hs_out) begin
                out_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter nb, default 32, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of 2).
REQ-003 SHALL have parameter LAT, default nb+2, rising edges from start sample to valid Product.
REQ-004 SHALL have port clk  input  1  clock, all flops on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  operand pair offered.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept.
REQ-008 SHALL have port in_a  input  nb  signed multiplicand.
REQ-009 SHALL have port in_b  input  nb  signed multiplier.
REQ-010 SHALL have port mul_start  output  1  start pulse to downstream multiplier.
REQ-011 SHALL have port mul_a  output  nb  multiplier A operand.
REQ-012 SHALL have port mul_b  output  nb  multiplier B operand.
REQ-013 SHALL have port mul_product  input  2*nb  multiplier Product.
REQ-014 SHALL have port out_valid  output  1  result available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port out_product  output  2*nb  captured signed product.
REQ-017 SHALL have port fifo_level  output  clog2(DEPTH)+1  entries held.

Function
REQ-018 SHALL push {in_a,in_b} on a rising edge with in_valid and in_ready both high.
REQ-019 SHALL drive in_ready = (fifo_level != DEPTH), from registered state only; no ready pass-through on same-cycle pop.
REQ-020 SHALL, on simultaneous push and pop, leave fifo_level unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-021 SHALL implement FSM IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE -> ISSUE when fifo_level != 0; else remain IDLE.
REQ-023 ISSUE: mul_start=1 for exactly one cycle, mul_a/mul_b = FIFO head, head popped at exit edge; ISSUE -> WAIT unconditionally.
REQ-024 WAIT: cycle counter counts LAT edges starting at the edge that sampled mul_start; mul_a/mul_b held stable; at the LAT-th edge out_product <= mul_product, out_valid <= 1, WAIT -> HOLD.
REQ-025 HOLD: out_valid and out_product held until out_ready high; on handshake edge out_valid <= 0, HOLD -> ISSUE if fifo_level != 0, else IDLE.
REQ-026 Latency: push at edge P into empty idle block SHALL give mul_start sampled at P+2 and out_valid high after edge P+2+LAT.
REQ-027 mul_start SHALL be a registered output, never high in WAIT or HOLD; at most one multiplication in flight.
REQ-028 Product SHALL be passed unmodified (2*nb two's complement); no truncation, no sign handling in this block.
REQ-029 Pushes SHALL continue to be accepted during WAIT and HOLD while not full.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, FIFO empty, fifo_level=0, in_ready=1, mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_product=0, counter=0.
REQ-031 Reset mid-operation SHALL discard the in-flight multiplication and all queued pairs; no out_valid for them after release.
REQ-032 First push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset: assert rst_n=0 at any state -> all outputs at REQ-030 values within same cycle.
REQ-034 Single op in_a=3, in_b=-5 with behavioural nb+2-latency multiplier -> mul_start one cycle with mul_a=3, mul_b=-5; out_valid after P+36, out_product=0xFFFFFFFFFFFFFFF1, held while out_ready=0.
REQ-035 Order: push (2,3), (-1,-1), (0x7FFFFFFF,2), out_ready=1 -> out_product 6, 1, 0x00000000FFFFFFFE in that order.
REQ-036 Full: six back-to-back pushes, out_ready=0 -> five accepted (first popped at ISSUE), fifo_level=4, in_ready=0, sixth held until a pop.
REQ-037 Extremes: (0x80000000,0x80000000) -> 0x4000000000000000; (0x80000000,0x7FFFFFFF) -> 0xC000000080000000.
REQ-038 Reset during WAIT -> out_valid stays 0, fifo_level=0; new op after release completes per REQ-026.
